// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    // Arbiter FSM: idle, or holding one memory access for the D or I port.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_D = 2'd1,
        ARB_BUSY_I = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_wait.sv
// Wait timer for an outstanding memory access.
// Counts cycles spent waiting for mem_ack. 'expired' flags the cycle in which
// the MAX_WAIT-th un-acked wait edge would occur, so the owner can abandon the
// access on that edge.
module mem_wait_timer
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count_reg;

    // Wait counter: cleared while no access is pending, saturates at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CNT_W'(MAX_WAIT))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between CPU fetch (I) and
// load/store (D). Data port has fixed priority. The CPU is stalled until every
// request raised for the current instruction has been served; read data is
// latched per port so it stays stable until the CPU advances.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall,
    output logic                bus_err
);

    arb_state_t          state_reg;
    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [DATA_W/8-1:0] mem_wmask_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;
    logic                if_srv_reg;
    logic                d_srv_reg;
    logic                bus_err_reg;

    logic busy;
    logic wait_expired;

    assign busy = (state_reg != ARB_IDLE);

    // A cycle counts as waiting only while busy and not being acknowledged.
    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy && !mem_ack),
        .expired (wait_expired)
    );

    // Stall while in reset or while any raised request is still unserved.
    always_comb begin
        stall = !rst || (if_req && !if_srv_reg) || (d_req && !d_srv_reg);
    end

    // Arbitration FSM, memory command registers, served flags and read latches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ARB_IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wmask_reg <= '0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            if_srv_reg    <= 1'b0;
            d_srv_reg     <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            // CPU advances on any non-stall edge; a completion on the same
            // edge (flushed request) still sets its flag, assigned below.
            if (!stall) begin
                if_srv_reg <= 1'b0;
                d_srv_reg  <= 1'b0;
            end

            case (state_reg)
                ARB_IDLE: begin
                    if (d_req && !d_srv_reg) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= d_we;
                        mem_addr_reg  <= d_addr;
                        mem_wdata_reg <= d_wdata;
                        mem_wmask_reg <= d_wmask;
                        state_reg     <= ARB_BUSY_D;
                    end else if (if_req && !if_srv_reg) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= if_addr;
                        mem_wdata_reg <= '0;
                        mem_wmask_reg <= '0;
                        state_reg     <= ARB_BUSY_I;
                    end
                end

                ARB_BUSY_D: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        d_srv_reg   <= 1'b1;
                        if (!mem_we_reg) begin
                            d_rdata_reg <= mem_rdata;
                        end
                        state_reg   <= ARB_IDLE;
                    end else if (wait_expired) begin
                        bus_err_reg <= 1'b1;
                        mem_req_reg <= 1'b0;
                        d_srv_reg   <= 1'b1;
                        d_rdata_reg <= '0;
                        state_reg   <= ARB_IDLE;
                    end
                end

                ARB_BUSY_I: begin
                    if (mem_ack) begin
                        mem_req_reg  <= 1'b0;
                        if_srv_reg   <= 1'b1;
                        if_rdata_reg <= mem_rdata;
                        state_reg    <= ARB_IDLE;
                    end else if (wait_expired) begin
                        bus_err_reg  <= 1'b1;
                        mem_req_reg  <= 1'b0;
                        if_srv_reg   <= 1'b1;
                        if_rdata_reg <= '0;
                        state_reg    <= ARB_IDLE;
                    end
                end

                default: begin
                    mem_req_reg <= 1'b0;
                    state_reg   <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wmask = mem_wmask_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural memory with configurable ack latency,
// access scoreboard, table of CPU request vectors plus hand-written sequences
// for reset, timeout and stray-ack cases.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        bus_err;

    mem_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } acc_t;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dmask;
        int          lat;
    } vec_t;

    acc_t exp_q[$];
    acc_t obs_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   ack_lat  = 3;
    bit   stray_tog = 1'b0;
    int   unstable_cnt;
    int   late_req_cnt;
    logic [31:0] exp_if;
    logic [31:0] exp_d;
    vec_t vt[6];

    // Memory contents seen by the arbiter.
    function automatic logic [31:0] data_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: records each new access, checks the command stays stable,
    // acks after ack_lat cycles (0 = never) and checks mem_req drops after ack.
    initial begin : mem_model
        acc_t cur;
        int   cnt;
        bit   in_access;
        bit   after_ack;
        bit   stray_seen;
        mem_ack      = 1'b0;
        mem_rdata    = '0;
        in_access    = 1'b0;
        after_ack    = 1'b0;
        stray_seen   = 1'b0;
        cnt          = 0;
        unstable_cnt = 0;
        late_req_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (after_ack) begin
                if (mem_req) late_req_cnt++;
                after_ack = 1'b0;
            end
            if (stray_tog != stray_seen) begin
                stray_seen = stray_tog;
                mem_ack    = 1'b1;
                mem_rdata  = 32'hBAD0BAD0;
            end else if (!rst) begin
                in_access = 1'b0;
            end else if (in_access) begin
                if (!mem_req) begin
                    in_access = 1'b0;
                end else begin
                    if (mem_we !== cur.we || mem_addr !== cur.addr ||
                        mem_wdata !== cur.wdata || mem_wmask !== cur.mask)
                        unstable_cnt++;
                    cnt++;
                    if (ack_lat > 0 && cnt >= ack_lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = data_fn(cur.addr);
                        in_access = 1'b0;
                        after_ack = 1'b1;
                    end
                end
            end else if (mem_req) begin
                cur.we    = mem_we;
                cur.addr  = mem_addr;
                cur.wdata = mem_wdata;
                cur.mask  = mem_wmask;
                obs_q.push_back(cur);
                in_access = 1'b1;
                cnt       = 1;
                if (ack_lat == 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = data_fn(cur.addr);
                    in_access = 1'b0;
                    after_ack = 1'b1;
                end
            end
        end
    end

    // Drive CPU requests and queue the memory accesses they must produce (D first).
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                         input logic [3:0] dm);
        acc_t e;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = dwd;
        d_wmask = dm;
        if (dr) begin
            e.we = dw; e.addr = da; e.wdata = dwd; e.mask = dm;
            exp_q.push_back(e);
        end
        if (ir) begin
            e.we = 1'b0; e.addr = ia; e.wdata = '0; e.mask = '0;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_cpu();
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wmask = '0;
    endtask

    task automatic wait_nostall(input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (stall && k < 200);
        chk({name, " stall released"}, 32'(stall), 32'd0);
    endtask

    // Compare observed memory accesses against the expected queue, in order.
    task automatic drain(input string name);
        acc_t e;
        acc_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL %s missing access: got none expected addr %h", name, e.addr);
            end else begin
                o = obs_q.pop_front();
                chk({name, " mem_addr"}, o.addr, e.addr);
                chk({name, " mem_we"}, 32'(o.we), 32'(e.we));
                chk({name, " mem_wdata"}, o.wdata, e.wdata);
                chk({name, " mem_wmask"}, 32'(o.mask), 32'(e.mask));
            end
        end
        chk({name, " extra accesses"}, 32'(obs_q.size()), 32'd0);
        obs_q.delete();
        chk({name, " cmd stable"}, 32'(unstable_cnt), 32'd0);
        chk({name, " req dropped after ack"}, 32'(late_req_cnt), 32'd0);
    endtask

    // One CPU instruction: raise requests, wait for release, check data, advance.
    task automatic run_vec(input string name, input vec_t v);
        ack_lat = v.lat;
        drive(v.ireq, v.iaddr, v.dreq, v.dwe, v.daddr, v.dwdata, v.dmask);
        if (v.ireq) exp_if = data_fn(v.iaddr);
        if (v.dreq && !v.dwe) exp_d = data_fn(v.daddr);
        wait_nostall(name);
        chk({name, " if_rdata"}, if_rdata, exp_if);
        chk({name, " d_rdata"}, d_rdata, exp_d);
        drain(name);
        step();
        idle_cpu();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t v;
        rst = 1'b0;
        idle_cpu();
        if_req  = 1'b1;
        if_addr = 32'h40;

        // Reset held with a fetch pending: stalled, no memory request.
        repeat (3) begin
            step();
            chk("reset stall", 32'(stall), 32'd1);
            chk("reset mem_req", 32'(mem_req), 32'd0);
        end
        chk("reset if_rdata", if_rdata, 32'd0);
        chk("reset d_rdata", d_rdata, 32'd0);
        chk("reset bus_err", 32'(bus_err), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);

        // Release reset: fetch of 0x40 issued on the next edge, acked 3 cycles later.
        ack_lat = 3;
        rst = 1'b1;
        drive(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, '0);
        step();
        chk("fetch issue mem_req", 32'(mem_req), 32'd1);
        chk("fetch issue mem_addr", mem_addr, 32'h40);
        chk("fetch issue stall", 32'(stall), 32'd1);
        wait_nostall("fetch");
        chk("fetch if_rdata", if_rdata, 32'hDEADBEEF);
        drain("fetch");
        step();
        idle_cpu();

        exp_if = 32'hDEADBEEF;
        exp_d  = 32'd0;
        vt[0] = '{1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0,        4'b0000, 2};
        vt[1] = '{1'b1, 32'h48, 1'b1, 1'b1, 32'h200, 32'h1234,     4'b0011, 4};
        vt[2] = '{1'b1, 32'h4C, 1'b0, 1'b0, 32'h0,   32'h0,        4'b0000, 1};
        vt[3] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h300, 32'h0,        4'b0000, 5};
        vt[4] = '{1'b1, 32'h50, 1'b1, 1'b1, 32'h204, 32'hCAFE0000, 4'b1100, 1};
        vt[5] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h40,  32'h0,        4'b0000, 2};
        for (int i = 0; i < 6; i++) begin
            run_vec($sformatf("vec%0d", i), vt[i]);
        end

        // Timeout: fetch never acknowledged.
        ack_lat = 0;
        drive(1'b1, 32'h80, 1'b0, 1'b0, '0, '0, '0);
        step();
        chk("timeout issue mem_req", 32'(mem_req), 32'd1);
        for (int k = 1; k < 16; k++) begin
            step();
            chk($sformatf("timeout wait%0d bus_err", k), 32'(bus_err), 32'd0);
        end
        step();
        chk("timeout bus_err", 32'(bus_err), 32'd1);
        chk("timeout if_rdata", if_rdata, 32'd0);
        chk("timeout stall", 32'(stall), 32'd0);
        chk("timeout mem_req", 32'(mem_req), 32'd0);
        drain("timeout");
        step();
        idle_cpu();
        repeat (3) step();
        chk("timeout sticky", 32'(bus_err), 32'd1);
        exp_if = 32'd0;
        v = '{1'b1, 32'h54, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 2};
        run_vec("post-timeout", v);
        chk("post-timeout sticky", 32'(bus_err), 32'd1);

        // Reset in the middle of a load, then a stray ack while idle.
        ack_lat = 0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 4'b0000);
        step();
        chk("abort issue mem_req", 32'(mem_req), 32'd1);
        step();
        step();
        rst = 1'b0;
        step();
        chk("abort mem_req", 32'(mem_req), 32'd0);
        chk("abort stall", 32'(stall), 32'd1);
        chk("abort bus_err", 32'(bus_err), 32'd0);
        chk("abort d_rdata", d_rdata, 32'd0);
        idle_cpu();
        rst = 1'b1;
        step();
        chk("abort released stall", 32'(stall), 32'd0);
        drain("abort");
        @(negedge clk);
        stray_tog = ~stray_tog;
        step();
        step();
        step();
        chk("stray d_rdata", d_rdata, 32'd0);
        chk("stray if_rdata", if_rdata, 32'd0);
        chk("stray mem_req", 32'(mem_req), 32'd0);
        chk("stray stall", 32'(stall), 32'd0);
        exp_if = 32'd0;
        exp_d  = 32'd0;
        v = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 4'b0000, 2};
        run_vec("after-stray load", v);
        v = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 2};
        run_vec("after-stray fetch", v);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
